uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that serialises one byte per request into an 8N1 frame: a start bit, 8 data bits LSB first, then a stop bit, at a fixed baud rate derived from the system clock. It is the transmit half of the board's serial link and drives the FPGA `tx` pin. It uses the same clock, baud constants and bit order as `uart_rx`, so a `tx`→`rx` loopback reproduces every byte.

## Interface
- `CLOCK_FREQUENCY`, default 100000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate.
- `BAUD_DIVIDE`, derived as CLOCK_FREQUENCY/BAUD_RATE with integer truncation (10416 by default): clock cycles per bit. Must be ≥ 2.
- `clock`  in  1  system clock. All logic runs on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  8  byte to send. Sampled only on the accept cycle.
- `start`  in  1  request to send. Level-sensitive; accepted when `busy`=0.
- `busy`  out  1  frame in progress. Reset value 0.
- `done`  out  1  one-cycle pulse marking the end of the stop bit. Reset value 0.
- `tx`  out  1  registered serial line. Idles high. Reset value 1.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP. PARITY is reachable only when the parity feature is compiled in.
- IDLE:
  - `tx`=1, `busy`=0.
  - If `start`=1, the request is accepted:
    - `data` is loaded into the shift register.
    - The baud counter is cleared and the bit index is cleared.
    - Next state is START; `tx`←0 and `busy`←1.
- Baud counter: 16 bits. It counts 0 … BAUD_DIVIDE-1. A bit ends on the cycle where count == BAUD_DIVIDE-1; the counter then wraps to 0.
- START: at bit end, go to DATA with `tx`←shift[0].
- DATA:
  - At each bit end, shift right and increment the 3-bit index.
  - Index wraps 7→0 while leaving DATA.
  - After bit 7, go to PARITY if enabled, else to STOP with `tx`←1.
- PARITY: at bit end, go to STOP with `tx`←1.
- STOP: at bit end, go to IDLE with `busy`←0 and `done`←1 for exactly one cycle.
- `start` while `busy`=1 is ignored. It causes no queueing, no data capture and no glitch on `tx`.
- Changes on `data` during a frame have no effect on that frame.
- `start` held high continuously produces back-to-back frames. Each new request is accepted in the IDLE cycle that follows `done`.
- Reset mid-frame: on the next edge, state←IDLE, `tx`←1, `busy`←0, `done`←0, and all counters and the shift register are cleared. No partial frame is completed.
- `reset` has priority over `start` in the same cycle.

## Timing
- Accept edge E: `tx` falls and `busy` rises at E, i.e. visible in the cycle after `start` is sampled. Latency from request to start bit is 1 cycle.
- Every bit, start, data, parity and stop, is exactly BAUD_DIVIDE cycles.
- Frame length is 10·BAUD_DIVIDE cycles, or 11·BAUD_DIVIDE cycles with parity.
- `done` is high in the first cycle after the stop bit, coincident with `busy`=0.
- Minimum line-high time between frames is BAUD_DIVIDE+1 cycles: the stop bit plus one IDLE cycle.
- Request-to-next-request throughput is 10·BAUD_DIVIDE+1 cycles (11·BAUD_DIVIDE+1 with parity).

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: an even parity bit, the XOR of the 8 data bits, is inserted between data bit 7 and the stop bit, giving an 11-bit frame. The paired receiver must be built to expect the parity bit.
- Undefined: 8N1 with a 10-bit frame. The PARITY state and the parity logic are absent.

## Structure
- Package `uart_pkg` holds:
  - default `CLOCK_FREQUENCY` and `BAUD_RATE`;
  - the FSM state typedef;
  - constants `UART_DATA_BITS`=8 and `UART_FRAME_BITS`, which is 10, or 11 under `UART_TX_PARITY_EN`.
  
  `uart_pkg` is shared with `uart_rx`.
- Sub-module `uart_baud_gen`:
  - Parameter: BAUD_DIVIDE.
  - Inputs: `clock`, `reset`, `clear`.
  - Output: `tick`, high when count == BAUD_DIVIDE-1.
  - `uart_tx` drives `clear` on accept.
  - The sub-module is reusable by `uart_rx`.

## Test plan
Bench uses CLOCK_FREQUENCY=16, BAUD_RATE=1 (BAUD_DIVIDE=16).
- Reset asserted 3 cycles → `tx`=1, `busy`=0, `done`=0. `start`=1 during reset produces no frame.
- `start` pulse with `data`=0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each value held 16 cycles. `busy` is high for 160 cycles and `done` pulses once, in the cycle `busy` falls.
- 0xA3 accepted; `start`+`data`=0xFF applied at cycle 40 → the frame still carries 0xA3 (bits 1,1,0,0,0,1,0,1). No second frame follows.
- `start` held high with 0x0F, switched to 0xF0 mid-frame → second frame carries 0xF0. Its start bit falls exactly 1 cycle after `done`, i.e. the line is high for 17 cycles between frames.
- Reset during data bit 4 of 0x3C → `tx`=1 and `busy`=0 one cycle later. A following 0x81 is sent intact, checked by loopback into `uart_rx`.
- With `UART_TX_PARITY_EN`: 0x07 → parity bit 1; 0x03 → parity bit 0. Each frame is 176 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART transmitter and receiver.
// Holds the default clock and baud settings, the frame geometry and the
// transmit FSM state type.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, frames carry
// an even parity bit and the PARITY state exists.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DEFAULT_CLOCK_FREQUENCY = 100_000_000;
  localparam int DEFAULT_BAUD_RATE       = 9600;
  localparam int UART_DATA_BITS          = 8;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: request/status bundle between a byte producer and uart_tx.
// Signals:
//   data  [7:0] byte to send (producer -> transmitter)
//   start       level-sensitive send request (producer -> transmitter)
//   busy        frame in progress (transmitter -> producer)
//   done        one-cycle end-of-frame pulse (transmitter -> producer)
//   tx          serial line (transmitter -> pin)
// Modports: master = producer side, slave = transmitter side.
`timescale 1ns/1ps
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] data;
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      tx;

  modport master (
    output data,
    output start,
    input  busy,
    input  done,
    input  tx
  );

  modport slave (
    input  data,
    input  start,
    output busy,
    output done,
    output tx
  );

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART.
// A 16-bit counter runs 0 .. BAUD_DIVIDE-1 and wraps; tick marks the last
// cycle of each bit period. clear restarts the period so a new frame's first
// bit is a full BAUD_DIVIDE cycles long.
// Ports:
//   clock  in   system clock (posedge)
//   reset  in   synchronous, active-high
//   clear  in   restart the bit period on the next edge
//   tick   out  high while count == BAUD_DIVIDE-1
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int BAUD_DIVIDE = 10416
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] COUNT_LAST = 16'(BAUD_DIVIDE - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  assign tick = (count_q == COUNT_LAST);

  always_comb begin
    count_d = count_q + 16'd1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Serialises one byte per accepted request into
// a start bit, 8 data bits LSB first, an optional even parity bit and a stop
// bit, each BAUD_DIVIDE clock cycles long.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit, 11-bit frame).
// Ports:
//   clock  in      system clock (posedge)
//   reset  in      synchronous, active-high; aborts any frame in progress
//   bus    slave   data/start request in, busy/done/tx out (see uart_tx_if)
// Parameters:
//   CLOCK_FREQUENCY, BAUD_RATE  clock and line rate in Hz / baud
//   BAUD_DIVIDE                 clock cycles per bit (must be >= 2)
`timescale 1ns/1ps
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int BAUD_DIVIDE     = CLOCK_FREQUENCY / BAUD_RATE
) (
  input logic      clock,
  input logic      reset,
  uart_tx_if.slave bus
);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                idx_q, idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic accept;
  logic baud_tick;

  // accept restarts the bit period so the start bit gets its full length.
  uart_baud_gen #(
    .BAUD_DIVIDE(BAUD_DIVIDE)
  ) u_baud_gen (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .tick (baud_tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          accept   = 1'b1;
          shift_d  = bus.data;
          idx_d    = 3'd0;
          state_d  = ST_START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(bus.data);
`endif
        end
      end

      ST_START: begin
        if (baud_tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          // 3-bit index wraps 7 -> 0 on the way out of DATA.
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // Next bit is the one about to land in shift[0].
            tx_d = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        if (baud_tick) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at 16 clocks per bit.
// A line-level receiver model decodes every frame on tx and compares it with
// the bytes queued when the requests were made; the main sequence also
// checks tx/busy/done cycle by cycle through each frame.
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DIV   = 16;
  localparam int FB    = UART_FRAME_BITS;
  localparam int FRAME = FB * DIV;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] sb_q[$];

  uart_tx_if bus();

  uart_tx #(
    .CLOCK_FREQUENCY(16),
    .BAUD_RATE      (1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] bits;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    bits[9]   = ^b;
`endif
    return bits;
  endfunction

  // Present a request and let the accept edge happen.
  task automatic request(input logic [7:0] b, input bit push, input bit hold);
    bus.data  = b;
    bus.start = 1'b1;
    if (push) sb_q.push_back(b);
    step();
    if (!hold) begin
      bus.start = 1'b0;
      bus.data  = ~b;
    end
  endtask

  // Walk one frame from its first cycle, checking every cycle; optionally
  // raise start / change data at set_at and drop start at clr_at.
  task automatic run_frame(input logic [7:0] b, input int set_at, input logic [7:0] set_data,
                           input bit set_push, input int clr_at);
    logic [10:0] bits;
    bits = frame_bits(b);
    for (int c = 0; c < FRAME; c++) begin
      if (c == set_at) begin
        bus.start = 1'b1;
        bus.data  = set_data;
        if (set_push) sb_q.push_back(set_data);
      end
      if (c == clr_at) bus.start = 1'b0;
      check($sformatf("tx_bit%0d", c / DIV), {31'd0, bus.tx}, {31'd0, bits[c / DIV]});
      check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
      check("done_in_frame", {31'd0, bus.done}, 32'd0);
      step();
    end
    check("busy_after_stop", {31'd0, bus.busy}, 32'd0);
    check("done_after_stop", {31'd0, bus.done}, 32'd1);
    check("tx_after_stop", {31'd0, bus.tx}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("tx_idle", {31'd0, bus.tx}, 32'd1);
      check("busy_idle", {31'd0, bus.busy}, 32'd0);
      check("done_idle", {31'd0, bus.done}, 32'd0);
    end
  endtask

  // Loopback receiver: sample the middle of each bit after a falling edge.
  initial begin : rx_model
    logic [10:0] rxb;
    bit          aborted;
    logic [7:0]  expb;
    forever begin
      @(posedge clock);
      #2;
      if (reset === 1'b0 && bus.tx === 1'b0) begin
        aborted = 1'b0;
        rxb     = '1;
        for (int c = 1; c <= 8 + DIV * (FB - 1); c++) begin
          @(posedge clock);
          #2;
          if (reset !== 1'b0) aborted = 1'b1;
          if (c >= 8 && ((c - 8) % DIV) == 0) rxb[(c - 8) / DIV] = bus.tx;
        end
        if (!aborted) begin
          check("rx_frame_expected", {31'd0, sb_q.size() != 0}, 32'd1);
          if (sb_q.size() != 0) begin
            expb = sb_q.pop_front();
            check("rx_start_bit", {31'd0, rxb[0]}, 32'd0);
            check("rx_byte", {24'd0, rxb[8:1]}, {24'd0, expb});
`ifdef UART_TX_PARITY_EN
            check("rx_parity", {31'd0, rxb[9]}, {31'd0, ^expb});
`endif
            check("rx_stop_bit", {31'd0, rxb[FB - 1]}, 32'd1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(100000 * 10);
    $display("FAIL timeout: observed no finish expected finish within 100000 cycles");
    $fatal(1);
  end

  initial begin : main
    logic [10:0] bits;

    // Reset with start held high: no frame may come out of it.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_tx", {31'd0, bus.tx}, 32'd1);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
    end
    reset     = 1'b0;
    bus.start = 1'b0;
    idle_cycles(8);

    // 0x55: alternating line, one done pulse.
    request(8'h55, 1'b1, 1'b0);
    run_frame(8'h55, -1, 8'h00, 1'b0, -1);
    idle_cycles(4);

    // 0xA3 with a start+0xFF attempt mid-frame: ignored, no second frame.
    request(8'hA3, 1'b1, 1'b0);
    run_frame(8'hA3, 40, 8'hFF, 1'b0, 100);
    idle_cycles(24);

    // start held: 0x0F then 0xF0 back to back, 17 high cycles between.
    request(8'h0F, 1'b1, 1'b1);
    run_frame(8'h0F, 80, 8'hF0, 1'b1, -1);
    step();
    run_frame(8'hF0, -1, 8'h00, 1'b0, 3);
    idle_cycles(4);

    // Reset during data bit 4 of 0x3C, then 0x81 intact.
    request(8'h3C, 1'b0, 1'b0);
    bits = frame_bits(8'h3C);
    for (int c = 0; c < 85; c++) begin
      check($sformatf("tx_pre_reset_bit%0d", c / DIV), {31'd0, bus.tx}, {31'd0, bits[c / DIV]});
      step();
    end
    reset = 1'b1;
    step();
    check("midreset_tx", {31'd0, bus.tx}, 32'd1);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;
    idle_cycles(100);
    request(8'h81, 1'b1, 1'b0);
    run_frame(8'h81, -1, 8'h00, 1'b0, -1);
    idle_cycles(4);

`ifdef UART_TX_PARITY_EN
    request(8'h07, 1'b1, 1'b0);
    run_frame(8'h07, -1, 8'h00, 1'b0, -1);
    idle_cycles(4);
    request(8'h03, 1'b1, 1'b0);
    run_frame(8'h03, -1, 8'h00, 1'b0, -1);
    idle_cycles(4);
`endif

    for (int i = 0; i < 400 && sb_q.size() != 0; i++) step();
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
